// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the unified memory port: IDLE -> ISSUE -> WAIT -> RESP.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is strict core-first priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_L = 4'(LATENCY);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       we_r;
  logic       grant;
  logic       pick;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    grant   = 1'b0;
`ifdef MEM_ARB_RR_EN
    // On a tie the pointer hands the grant to whoever did not win last time.
    if (c_req && d_req) pick = ~owner;
    else                pick = d_req;
`else
    pick = ~c_req;
`endif
    unique case (state)
      IDLE: begin
        if (c_req || d_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_L;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      owner   <= 1'b1;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata   <= '0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      m_en  <= 1'b0;
      m_we  <= 1'b0;
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (state_d != IDLE);
      if (grant) begin
        // The winner's fields go straight into the port registers so ISSUE drives them with no extra stage.
        owner   <= pick;
        we_r    <= pick ? d_we : c_we;
        m_en    <= 1'b1;
        m_we    <= pick ? d_we : c_we;
        m_addr  <= pick ? d_addr : c_addr;
        m_wdata <= pick ? d_wdata : c_wdata;
      end
      if (state == WAIT && cnt == 4'd1) begin
        if (!we_r) rdata <= m_rdata;
        if (owner) d_ack <= 1'b1;
        else       c_ack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a LATENCY=3 main instance checked by a queue-driven monitor,
// plus a LATENCY=1 instance for the single-cycle-latency read timing.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  typedef struct {
    bit          dev;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          issue_at;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, d_ack, m_en, m_we, busy, owner;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;

  logic        c_req1;
  logic        c_ack1, d_ack1, m_en1, m_we1, busy1, owner1;
  logic [31:0] rdata1, m_addr1, m_wdata1, m_rdata1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   acks_seen = 0;
  logic [31:0] last_rd = '0;
  txn_t exp_q[$];
  txn_t mon_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign m_rdata  = mem_f(m_addr);
  assign m_rdata1 = mem_f(m_addr1);

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .c_req(c_req1), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack1),
    .d_req(1'b0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1),
    .rdata(rdata1), .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata1), .busy(busy1), .owner(owner1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_c(input bit we, input logic [31:0] a, input logic [31:0] wd);
    c_we = we; c_addr = a; c_wdata = wd; c_req = 1'b1;
  endtask

  task automatic start_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
  endtask

  task automatic push(input bit dev, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input int issue_at);
    txn_t t;
    t.dev = dev; t.we = we; t.addr = a; t.wdata = wd;
    t.rdata = mem_f(a); t.issue_at = issue_at;
    exp_q.push_back(t);
  endtask

  // Returns while the last expected ack is still high (RESP cycle).
  task automatic wait_acks(input int n);
    int target;
    target = acks_seen + n;
    for (int i = 0; i < 200 && acks_seen < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("ack_wait_budget", 64'(acks_seen >= target), 64'd1);
  endtask

  // Monitor: issue fields and ack order/latency/data against the scoreboard queue.
  always @(negedge clk) begin
    if (!reset) begin
      check("dual_ack", 64'(c_ack & d_ack), 64'd0);
      if (!m_en) check("m_we_outside_issue", 64'(m_we), 64'd0);
      if (m_en) begin
        check("issue_has_txn", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_t = exp_q[0];
          check("issue_addr", 64'(m_addr), 64'(mon_t.addr));
          check("issue_we", 64'(m_we), 64'(mon_t.we));
          if (mon_t.we) check("issue_wdata", 64'(m_wdata), 64'(mon_t.wdata));
          if (mon_t.issue_at >= 0) check("issue_cycle", 64'(cyc), 64'(mon_t.issue_at));
          issue_cyc = cyc;
        end
      end
      if (c_ack || d_ack) begin
        check("ack_has_txn", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_t = exp_q.pop_front();
          check("ack_is_dev", 64'(d_ack), 64'(mon_t.dev));
          check("ack_owner", 64'(owner), 64'(mon_t.dev));
          check("ack_latency", 64'(cyc - issue_cyc), 64'(LAT + 1));
          check("ack_busy", 64'(busy), 64'd1);
          if (!mon_t.we) last_rd = mon_t.rdata;
          check("ack_rdata", 64'(rdata), 64'(last_rd));
          acks_seen++;
        end
      end
    end
  end

  initial begin
    int t0;
    int stray;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_req1 = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    repeat (2) @(negedge clk);
    check("rst_m_en", 64'(m_en), 64'd0);
    check("rst_m_we", 64'(m_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_c_ack", 64'(c_ack), 64'd0);
    check("rst_d_ack", 64'(d_ack), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_wdata", 64'(m_wdata), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_owner", 64'(owner), 64'd1);
    check("rst_l1_owner", 64'(owner1), 64'd1);
    #1 reset = 1'b0;

    // LATENCY=1 core read: m_en at T+1, c_ack at T+3.
    tick;
    c_we = 0; c_addr = 32'h100; c_req1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("l1_m_en", 64'(m_en1), 64'(k == 1));
      if (k == 1) check("l1_m_addr", 64'(m_addr1), 64'h100);
      check("l1_c_ack", 64'(c_ack1), 64'(k == 3));
      check("l1_d_ack", 64'(d_ack1), 64'd0);
    end
    check("l1_rdata", 64'(rdata1), 64'hDEADBEEF);
    tick;
    c_req1 = 1'b0;
    @(negedge clk);
    check("l1_idle_busy", 64'(busy1), 64'd0);
    check("l1_idle_ack", 64'(c_ack1), 64'd0);

    // Main instance core read.
    tick;
    start_c(1'b0, 32'h100, 32'h0);
    push(1'b0, 1'b0, 32'h100, 32'h0, cyc + 1);
    wait_acks(1);
    tick;
    c_req = 1'b0;

    // Second-requester write leaves rdata untouched.
    tick;
    start_d(1'b1, 32'h40, 32'h12345678);
    push(1'b1, 1'b1, 32'h40, 32'h12345678, cyc + 1);
    wait_acks(1);
    tick;
    d_req = 1'b0;
    check("rdata_after_write", 64'(rdata), 64'hDEADBEEF);

    // Both requests held: one access per LAT+3 cycles.
    tick;
    start_c(1'b0, 32'h200, 32'h0);
    start_d(1'b0, 32'h300, 32'h0);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      if (i % 2 == 1) push(1'b1, 1'b0, 32'h300, 32'h0, t0 + 1 + i * (LAT + 3));
      else            push(1'b0, 1'b0, 32'h200, 32'h0, t0 + 1 + i * (LAT + 3));
`else
      push(1'b0, 1'b0, 32'h200, 32'h0, t0 + 1 + i * (LAT + 3));
`endif
    end
    wait_acks(4);
    tick;
    c_req = 1'b0;
    d_req = 1'b0;

    // Reset during WAIT aborts the access with no ack.
    tick;
    start_c(1'b0, 32'h500, 32'h0);
    push(1'b0, 1'b0, 32'h500, 32'h0, cyc + 1);
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("midrst_m_en", 64'(m_en), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_owner", 64'(owner), 64'd1);
    check("midrst_c_ack", 64'(c_ack), 64'd0);
    check("midrst_d_ack", 64'(d_ack), 64'd0);
    c_req = 1'b0;
    exp_q.delete();
    last_rd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      stray += int'(c_ack | d_ack);
    end
    check("no_ack_after_reset", 64'(stray), 64'd0);
    tick;
    start_c(1'b0, 32'h500, 32'h0);
    push(1'b0, 1'b0, 32'h500, 32'h0, cyc + 1);
    wait_acks(1);
    tick;
    c_req = 1'b0;

    // Core drops req after grant; pending second-requester write is served next.
    tick;
    start_c(1'b0, 32'h600, 32'h0);
    t0 = cyc;
    push(1'b0, 1'b0, 32'h600, 32'h0, t0 + 1);
    push(1'b1, 1'b1, 32'h700, 32'hCAFEF00D, t0 + LAT + 4);
    tick;
    c_req = 1'b0;
    start_d(1'b1, 32'h700, 32'hCAFEF00D);
    wait_acks(2);
    tick;
    d_req = 1'b0;

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
